subtractors3_pipelined: RTL



---
 rtl/subtractors3_pipelined_pkg.sv | 31 +++
 rtl/subtractors3_pipelined_if.sv | 27 ++
 rtl/subtractors3_pipelined_pipe_stage_ctl.sv | 30 +++
 rtl/subtractors3_pipelined.sv | 78 +++++++
 4 files changed

// File: rtl/subtractors3_pipelined_pkg.sv
// Shared widths and stage payload types for the two-stage subtractor pipeline.
package subtractors3_pipelined_pkg;

  localparam int unsigned A_W  = 4;
  localparam int unsigned C_W  = 8;
  localparam int unsigned D1_W = 5;
  localparam int unsigned D2_W = 9;
  localparam int unsigned D3_W = 10;

  typedef struct packed {
    logic [D1_W-1:0] diff1;
    logic [D2_W-1:0] diff2;
  } s1_data_t;

  typedef struct packed {
    logic [D1_W-1:0] diff1;
    logic [D2_W-1:0] diff2;
    logic [D3_W-1:0] diff3;
  } s2_data_t;

  // Sign-extend both first-stage differences to D3_W and subtract.
  function automatic logic [D3_W-1:0] diff_of_diffs(input logic [D1_W-1:0] d1,
                                                     input logic [D2_W-1:0] d2);
    logic [D3_W-1:0] x1;
    logic [D3_W-1:0] x2;
    x1 = {{(D3_W-D1_W){d1[D1_W-1]}}, d1};
    x2 = {{(D3_W-D2_W){d2[D2_W-1]}}, d2};
    return x1 - x2;
  endfunction

endpackage

// File: rtl/subtractors3_pipelined_if.sv
// Operand/result handshake bundle between a producer/consumer and the subtractor pipeline.
interface subtractors3_pipelined_if;
  import subtractors3_pipelined_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [A_W-1:0]  a;
  logic [A_W-1:0]  b;
  logic [C_W-1:0]  c;
  logic [C_W-1:0]  d;
  logic            out_valid;
  logic            out_ready;
  logic [D1_W-1:0] diff1;
  logic [D2_W-1:0] diff2;
  logic [D3_W-1:0] diff3;

  modport master (
    output in_valid, a, b, c, d, out_ready,
    input  in_ready, out_valid, diff1, diff2, diff3
  );

  modport slave (
    input  in_valid, a, b, c, d, out_ready,
    output in_ready, out_valid, diff1, diff2, diff3
  );

endinterface

// File: rtl/subtractors3_pipelined_pipe_stage_ctl.sv
// Valid/ready bookkeeping for one pipeline stage: holds the stage valid bit and
// produces the stage advance (ready) and data load-enable strobes.
module pipe_stage_ctl (
  input  logic clk,
  input  logic reset_n,
  input  logic i_up_valid,
  input  logic i_dn_ready,
  output logic o_valid,
  output logic o_ready_c,
  output logic o_load_c
);

  logic r_valid;

  always_comb begin
    o_ready_c = !r_valid || i_dn_ready;
    o_load_c  = o_ready_c && i_up_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
    end else if (o_ready_c) begin
      r_valid <= i_up_valid;
    end
  end

  assign o_valid = r_valid;

endmodule

// File: rtl/subtractors3_pipelined.sv
// Two-stage pipelined subtractor: stage 1 forms a-b and c-d, stage 2 forms their
// signed difference; elastic valid/ready handshake on both ends.
module subtractors3_pipelined
  import subtractors3_pipelined_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  subtractors3_pipelined_if.slave  bus
);

  logic     w_s1_valid;
  logic     w_s1_ready;
  logic     w_s1_load;
  logic     w_s2_valid;
  logic     w_s2_ready;
  logic     w_s2_load;
  s1_data_t w_s1_next;
  s2_data_t w_s2_next;
  s1_data_t r_s1;
  s2_data_t r_s2;

  pipe_stage_ctl u_s1_ctl (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_up_valid (bus.in_valid),
    .i_dn_ready (w_s2_ready),
    .o_valid    (w_s1_valid),
    .o_ready_c  (w_s1_ready),
    .o_load_c   (w_s1_load)
  );

  pipe_stage_ctl u_s2_ctl (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_up_valid (w_s1_valid),
    .i_dn_ready (bus.out_ready),
    .o_valid    (w_s2_valid),
    .o_ready_c  (w_s2_ready),
    .o_load_c   (w_s2_load)
  );

  // Operands are unsigned, so widen with zeros before subtracting.
  always_comb begin
    w_s1_next       = '0;
    w_s1_next.diff1 = D1_W'(bus.a) - D1_W'(bus.b);
    w_s1_next.diff2 = D2_W'(bus.c) - D2_W'(bus.d);
  end

  always_comb begin
    w_s2_next       = '0;
    w_s2_next.diff1 = r_s1.diff1;
    w_s2_next.diff2 = r_s1.diff2;
    w_s2_next.diff3 = diff_of_diffs(r_s1.diff1, r_s1.diff2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
    end else if (w_s1_load) begin
      r_s1 <= w_s1_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2 <= '0;
    end else if (w_s2_load) begin
      r_s2 <= w_s2_next;
    end
  end

  assign bus.in_ready  = w_s1_ready;
  assign bus.out_valid = w_s2_valid;
  assign bus.diff1     = r_s2.diff1;
  assign bus.diff2     = r_s2.diff2;
  assign bus.diff3     = r_s2.diff3;

endmodule
